mem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the single-port word-wide program/data memory of the multi-cycle RV32I SOC. The CPU state machine issues instruction fetches on port I and loads/stores on port D. The block serialises these onto one synchronous RAM interface with round-robin fairness, configurable wait states and byte write masks, and returns a one-cycle done pulse per transaction.

---
 rtl/mem_arbiter_pkg.sv | 17 +
 rtl/mem_arbiter_if.sv | 33 +++
 rtl/mem_arbiter_rr.sv | 27 ++
 rtl/mem_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_arbiter.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    DATA  = 3'd3,
    RESP  = 3'd4
  } state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// CPU-side fetch/load-store ports plus the single-port RAM bus, bundled for the arbiter.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  i_req;
  logic [31:0]           i_addr;
  logic [31:0]           i_rdata;
  logic                  i_done;
  logic                  d_req;
  logic [31:0]           d_addr;
  logic [31:0]           d_wdata;
  logic [3:0]            d_wmask;
  logic [31:0]           d_rdata;
  logic                  d_done;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [3:0]            mem_wmask;
  logic                  mem_rstrb;
  logic [31:0]           mem_rdata;
  logic                  busy;

  modport slave (
    input  i_req, i_addr, d_req, d_addr, d_wdata, d_wmask, mem_rdata,
    output i_rdata, i_done, d_rdata, d_done,
    output mem_addr, mem_wdata, mem_wmask, mem_rstrb, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_addr, d_wdata, d_wmask, mem_rdata,
    input  i_rdata, i_done, d_rdata, d_done,
    input  mem_addr, mem_wdata, mem_wmask, mem_rstrb, busy
  );
endinterface

// File: rtl/mem_arbiter_rr.sv
// Two-request round-robin picker: combinational grant, registered last-grant pointer.
// On a tie the port not granted last wins; the pointer moves only when upd_i is high.
module rr_arbiter2
  import mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  output logic       vld_o,
  output logic       port_o
);

  logic last_q, last_d;

  always_comb begin
    vld_o  = |req_i;
    port_o = (&req_i) ? ~last_q : req_i[PORT_D];
    last_d = upd_i ? port_o : last_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= PORT_I;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises fetch (I) and load/store (D) onto one synchronous RAM with round-robin fairness.
// Read: 3+WAIT_STATES cycles grant-to-done, write: 2+WAIT_STATES; a losing request simply stays pending.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] WS_LOAD =
    (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

  state_t                state_q, state_d;
  logic                  port_q, port_d;
  logic                  wr_q, wr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic [3:0]            mem_wmask_q, mem_wmask_d;
  logic                  mem_rstrb_q, mem_rstrb_d;
  logic [31:0]           i_rdata_q, i_rdata_d;
  logic [31:0]           d_rdata_q, d_rdata_d;

  logic        gnt_vld, gnt_port, gnt_upd, gnt_wr;
  logic [31:0] sel_addr;
  logic        unused_addr_bits;

  rr_arbiter2 u_rr (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_i  ({bus.d_req, bus.i_req}),
    .upd_i  (gnt_upd),
    .vld_o  (gnt_vld),
    .port_o (gnt_port)
  );

  assign sel_addr = (gnt_port == PORT_D) ? bus.d_addr : bus.i_addr;
  assign gnt_wr   = (gnt_port == PORT_D) && (bus.d_wmask != 4'b0000);
  // Byte offset and bits beyond the RAM depth are dropped, so addresses wrap.
  assign unused_addr_bits = ^{sel_addr[31:ADDR_WIDTH+2], sel_addr[1:0]};

  always_comb begin
    state_d     = state_q;
    port_d      = port_q;
    wr_d        = wr_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = 4'b0000;
    mem_rstrb_d = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    gnt_upd     = 1'b0;

    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          gnt_upd    = 1'b1;
          port_d     = gnt_port;
          wr_d       = gnt_wr;
          mem_addr_d = sel_addr[ADDR_WIDTH+1:2];
          if (gnt_wr) begin
            mem_wmask_d = bus.d_wmask;
            mem_wdata_d = bus.d_wdata;
          end else begin
            mem_rstrb_d = 1'b1;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (WAIT_STATES > 0) begin
          cnt_d   = WS_LOAD;
          state_d = WAIT;
        end else begin
          state_d = wr_q ? RESP : DATA;
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = wr_q ? RESP : DATA;
        else             cnt_d   = cnt_q - 1'b1;
      end
      DATA: begin
        if (port_q == PORT_D) d_rdata_d = bus.mem_rdata;
        else                  i_rdata_d = bus.mem_rdata;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      port_q      <= PORT_I;
      wr_q        <= 1'b0;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      mem_rstrb_q <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      port_q      <= port_d;
      wr_q        <= wr_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
      mem_rstrb_q <= mem_rstrb_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wmask = mem_wmask_q;
  assign bus.mem_rstrb = mem_rstrb_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.i_done    = (state_q == RESP) && (port_q == PORT_I);
  assign bus.d_done    = (state_q == RESP) && (port_q == PORT_D);
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: one arbiter with no wait states, one with three, each backed by a small RAM model.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_WIDTH(8)) b0 ();
  mem_arbiter_if #(.ADDR_WIDTH(8)) b1 ();

  mem_arbiter #(.ADDR_WIDTH(8), .WAIT_STATES(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  mem_arbiter #(.ADDR_WIDTH(8), .WAIT_STATES(3)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  logic [31:0] ram0 [256];
  logic [31:0] ram1 [256];
  logic        pl_en, pl_sel;
  logic [7:0]  pl_addr;
  logic [31:0] pl_dat;

  always @(posedge clk) begin
    if (pl_en && !pl_sel) ram0[pl_addr] <= pl_dat;
    if (b0.mem_rstrb) b0.mem_rdata <= ram0[b0.mem_addr];
    for (int i = 0; i < 4; i++)
      if (b0.mem_wmask[i]) ram0[b0.mem_addr][8*i +: 8] <= b0.mem_wdata[8*i +: 8];
  end

  always @(posedge clk) begin
    if (pl_en && pl_sel) ram1[pl_addr] <= pl_dat;
    if (b1.mem_rstrb) b1.mem_rdata <= ram1[b1.mem_addr];
    for (int i = 0; i < 4; i++)
      if (b1.mem_wmask[i]) ram1[b1.mem_addr][8*i +: 8] <= b1.mem_wdata[8*i +: 8];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic sel, input logic [7:0] a, input logic [31:0] d);
    pl_sel  = sel;
    pl_addr = a;
    pl_dat  = d;
    pl_en   = 1'b1;
    @(negedge clk);
    pl_en   = 1'b0;
  endtask

  // Results of the most recent observed transaction
  bit          o_got;
  int          o_lat, o_iss_k, o_n_rstrb, o_n_wm;
  logic [7:0]  o_iss_addr;
  logic [3:0]  o_iss_wm;
  logic [1:0]  o_done;
  logic [31:0] o_irdata, o_drdata;

  // Call at the negedge where requests were driven; k counts negedges after that point.
  task automatic observe(input bit sel, input string tag);
    logic       rstrb;
    logic [3:0] wm;
    logic [7:0] addr;
    logic [1:0] done;
    o_got = 0; o_lat = 0; o_iss_k = 0; o_n_rstrb = 0; o_n_wm = 0;
    o_iss_addr = '0; o_iss_wm = '0; o_done = '0;
    for (int k = 1; k <= 50 && !o_got; k++) begin
      @(negedge clk);
      rstrb = sel ? b1.mem_rstrb : b0.mem_rstrb;
      wm    = sel ? b1.mem_wmask : b0.mem_wmask;
      addr  = sel ? b1.mem_addr  : b0.mem_addr;
      done  = sel ? {b1.d_done, b1.i_done} : {b0.d_done, b0.i_done};
      if (rstrb || wm != 4'b0) begin
        if (o_iss_k == 0) begin
          o_iss_k    = k;
          o_iss_addr = addr;
          o_iss_wm   = wm;
        end
        if (rstrb)        o_n_rstrb++;
        if (wm != 4'b0)   o_n_wm++;
      end
      if (done != 2'b00) begin
        o_got    = 1;
        o_lat    = k;
        o_done   = done;
        o_irdata = sel ? b1.i_rdata : b0.i_rdata;
        o_drdata = sel ? b1.d_rdata : b0.d_rdata;
      end
    end
    check({tag, "_done_seen"}, 32'(o_got), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n_done_rst;
    rst_n = 1'b0;
    pl_en = 1'b0; pl_sel = 1'b0; pl_addr = '0; pl_dat = '0;
    b0.i_req = 0; b0.i_addr = '0; b0.d_req = 0; b0.d_addr = '0; b0.d_wdata = '0; b0.d_wmask = '0;
    b1.i_req = 0; b1.i_addr = '0; b1.d_req = 0; b1.d_addr = '0; b1.d_wdata = '0; b1.d_wmask = '0;
    @(negedge clk);
    preload(1'b0, 8'd3, 32'h00A0_0113);
    preload(1'b0, 8'd5, 32'h1234_5678);
    preload(1'b0, 8'd4, 32'hAAAA_AAAA);
    preload(1'b0, 8'd1, 32'hCAFE_F00D);
    preload(1'b1, 8'd2, 32'h0BAD_C0DE);
    preload(1'b1, 8'd7, 32'h600D_1DEA);

    check("rst_busy",      32'(b0.busy),      32'd0);
    check("rst_i_done",    32'(b0.i_done),    32'd0);
    check("rst_d_done",    32'(b0.d_done),    32'd0);
    check("rst_mem_rstrb", 32'(b0.mem_rstrb), 32'd0);
    check("rst_mem_wmask", 32'(b0.mem_wmask), 32'd0);
    check("rst_mem_addr",  32'(b0.mem_addr),  32'd0);
    check("rst_mem_wdata", b0.mem_wdata,      32'd0);
    check("rst_i_rdata",   b0.i_rdata,        32'd0);
    check("rst_d_rdata",   b0.d_rdata,        32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single fetch, word 3
    b0.i_addr = 32'h0000_000C; b0.i_req = 1'b1;
    observe(1'b0, "fetch");
    b0.i_req = 1'b0;
    check("fetch_lat",     32'(o_lat),      32'd3);
    check("fetch_iss_k",   32'(o_iss_k),    32'd1);
    check("fetch_addr",    32'(o_iss_addr), 32'd3);
    check("fetch_n_rstrb", 32'(o_n_rstrb),  32'd1);
    check("fetch_port",    32'(o_done),     32'b01);
    check("fetch_rdata",   o_irdata,        32'h00A0_0113);
    @(negedge clk);
    check("fetch_idle_busy", 32'(b0.busy), 32'd0);

    // Load on D, word 5
    b0.d_addr = 32'h0000_0014; b0.d_wmask = 4'b0000; b0.d_req = 1'b1;
    observe(1'b0, "load");
    b0.d_req = 1'b0;
    check("load_lat",      32'(o_lat),  32'd3);
    check("load_port",     32'(o_done), 32'b10);
    check("load_rdata",    o_drdata,    32'h1234_5678);
    check("load_i_rdata",  b0.i_rdata,  32'h00A0_0113);
    @(negedge clk);

    // Store low half-word into word 4
    b0.d_addr = 32'h0000_0010; b0.d_wdata = 32'hDEAD_BEEF; b0.d_wmask = 4'b0011; b0.d_req = 1'b1;
    observe(1'b0, "store");
    b0.d_req = 1'b0; b0.d_wmask = 4'b0000;
    check("store_lat",     32'(o_lat),      32'd2);
    check("store_addr",    32'(o_iss_addr), 32'd4);
    check("store_wmask",   32'(o_iss_wm),   32'b0011);
    check("store_n_wm",    32'(o_n_wm),     32'd1);
    check("store_n_rstrb", 32'(o_n_rstrb),  32'd0);
    check("store_port",    32'(o_done),     32'b10);
    check("store_d_rdata", o_drdata,        32'h1234_5678);
    @(negedge clk);
    check("store_ram", ram0[4], 32'hAAAA_BEEF);

    // Address wrap: 0x404 lands on word 1
    b0.i_addr = 32'h0000_0404; b0.i_req = 1'b1;
    observe(1'b0, "wrap");
    b0.i_req = 1'b0;
    check("wrap_addr",  32'(o_iss_addr), 32'd1);
    check("wrap_rdata", o_irdata,        32'hCAFE_F00D);
    @(negedge clk);

    // Both ports held: last grant was I, so order is D,I,D,I,D,I
    b0.i_addr = 32'h0000_000C; b0.d_addr = 32'h0000_0004; b0.d_wmask = 4'b0000;
    b0.i_req = 1'b1; b0.d_req = 1'b1;
    for (int t = 0; t < 6; t++) begin
      observe(1'b0, "rr");
      if (t % 2 == 0) begin
        check("rr_port_d", 32'(o_done), 32'b10);
        check("rr_d_rdata", o_drdata,   32'hCAFE_F00D);
      end else begin
        check("rr_port_i", 32'(o_done), 32'b01);
        check("rr_i_rdata", o_irdata,   32'h00A0_0113);
      end
    end
    b0.i_req = 1'b0; b0.d_req = 1'b0;
    @(negedge clk);

    // Three wait states, load word 2
    b1.d_addr = 32'h0000_0008; b1.d_wmask = 4'b0000; b1.d_req = 1'b1;
    observe(1'b1, "ws3");
    b1.d_req = 1'b0;
    check("ws3_lat",     32'(o_lat),     32'd6);
    check("ws3_iss_k",   32'(o_iss_k),   32'd1);
    check("ws3_n_rstrb", 32'(o_n_rstrb), 32'd1);
    check("ws3_port",    32'(o_done),    32'b10);
    check("ws3_rdata",   o_drdata,       32'h0BAD_C0DE);
    @(negedge clk);

    // Reset while in WAIT, then a clean re-issued fetch of word 7
    b1.i_addr = 32'h0000_001C; b1.i_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("mid_busy_before", 32'(b1.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_busy",      32'(b1.busy),      32'd0);
    check("mid_mem_rstrb", 32'(b1.mem_rstrb), 32'd0);
    check("mid_mem_addr",  32'(b1.mem_addr),  32'd0);
    check("mid_mem_wmask", 32'(b1.mem_wmask), 32'd0);
    check("mid_mem_wdata", b1.mem_wdata,      32'd0);
    check("mid_i_rdata",   b1.i_rdata,        32'd0);
    check("mid_d_rdata",   b1.d_rdata,        32'd0);
    check("mid_i_done",    32'(b1.i_done),    32'd0);
    check("mid_d_done",    32'(b1.d_done),    32'd0);
    n_done_rst = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (b1.i_done || b1.d_done) n_done_rst++;
    end
    check("mid_no_done", 32'(n_done_rst), 32'd0);
    rst_n = 1'b1;
    observe(1'b1, "refetch");
    b1.i_req = 1'b0;
    check("refetch_lat",   32'(o_lat),  32'd6);
    check("refetch_port",  32'(o_done), 32'b01);
    check("refetch_rdata", o_irdata,    32'h600D_1DEA);
    @(negedge clk);
    check("refetch_idle", 32'(b1.busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
